softplus_grad_seq: RTL and testbench

- Backprop sequencer for the softplus-squared gradient LUT.
- Walks a vector of pre-activations z[i] and upstream errors delta[i] held in layer buffer memory (Q8.8 signed).
- Drives the combinational gradient LUT, computes delta[i]*grad(z[i]) in Q8.8, and streams the results to the gradient buffer.
- Sits between the layer buffers and the weight-update unit.
- One element per cycle, with write-side backpressure.

---
 rtl/softplus_grad_seq_if.sv | 36 +++
 rtl/softplus_grad_seq.sv | 139 +++++++++++++
 tb/tb_softplus_grad_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/softplus_grad_seq_if.sv
// Port bundle for the softplus-gradient backprop sequencer: control, source read,
// gradient LUT and destination write channels.
interface softplus_grad_seq_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 16
);
   logic              start;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              done;

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_z;
   logic [DATA_W-1:0] rd_delta;

   logic [DATA_W-1:0] lut_operand;
   logic [DATA_W-1:0] lut_grad;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;

   // Sequencer side.
   modport master (
      input  start, len, rd_z, rd_delta, lut_grad, wr_ready,
      output busy, done, rd_en, rd_addr, lut_operand, wr_en, wr_addr, wr_data
   );

   // Environment side: controller, layer buffers, LUT and gradient buffer.
   modport slave (
      output start, len, rd_z, rd_delta, lut_grad, wr_ready,
      input  busy, done, rd_en, rd_addr, lut_operand, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/softplus_grad_seq.sv
// Backprop sequencer: streams delta[i] * grad(z[i]) (Q8.8, saturated) from the layer
// buffers to the gradient buffer, one element per cycle with write-side backpressure.
module softplus_grad_seq #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 16
) (
   input logic                 clk,
   input logic                 rst,
   softplus_grad_seq_if.master bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;

   // Read issued last cycle: its data is on rd_z/rd_delta now.
   logic                pend_q;
   logic [ADDR_W-1:0]   pend_idx_q;

   logic                s1_v_q;
   logic [DATA_W-2:0]   s1_grad_q;
   logic [DATA_W-1:0]   s1_delta_q;
   logic [ADDR_W-1:0]   s1_idx_q;

   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;

   logic                stall;
   logic                rd_fire;
   logic                last_rd;
   logic                pipe_empty;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [2*DATA_W-1:0] shifted;
   logic [DATA_W:0]     hi_bits;
   logic [DATA_W-1:0]   sat;

   assign stall      = wr_en_q & ~bus.wr_ready;
   assign rd_fire    = (state_q == StRun) & ~stall;
   assign last_rd    = ({1'b0, rd_idx_q} + (ADDR_W + 1)'(1)) == len_q;
   assign pipe_empty = ~pend_q & ~s1_v_q & (~wr_en_q | bus.wr_ready);

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rd_idx_d = rd_idx_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  len_d    = bus.len;
                  rd_idx_d = '0;
                  state_d  = StRun;
               end else begin
                  state_d = StFin;
               end
            end
         end
         StRun: begin
            if (rd_fire) begin
               // Wraps to 0 after the last read of a full-length vector.
               rd_idx_d = rd_idx_q + ADDR_W'(1);
               if (last_rd) state_d = StDrain;
            end
         end
         StDrain: begin
            if (pipe_empty) state_d = StFin;
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Gradient magnitude is unsigned; its top bit is ignored so it multiplies as positive.
   assign prod    = $signed(s1_delta_q) * $signed({1'b0, s1_grad_q});
   assign shifted = prod >>> (DATA_W / 2);
   assign hi_bits = shifted[2*DATA_W-1:DATA_W-1];

   always_comb begin
      sat = shifted[DATA_W-1:0];
      if (hi_bits != '0 && hi_bits != '1) begin
         sat = shifted[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         len_q      <= '0;
         rd_idx_q   <= '0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         s1_v_q     <= 1'b0;
         s1_grad_q  <= '0;
         s1_delta_q <= '0;
         s1_idx_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         rd_idx_q <= rd_idx_d;
         // A stall freezes every stage; the buffer holds the pending read data meanwhile.
         if (!stall) begin
            pend_q     <= rd_fire;
            pend_idx_q <= rd_idx_q;
            s1_v_q     <= pend_q;
            if (pend_q) begin
               s1_grad_q  <= bus.lut_grad[DATA_W-2:0];
               s1_delta_q <= bus.rd_delta;
               s1_idx_q   <= pend_idx_q;
            end
            wr_en_q <= s1_v_q;
            if (s1_v_q) begin
               wr_data_q <= sat;
               wr_addr_q <= s1_idx_q;
            end
         end
      end
   end

   assign bus.busy        = (state_q != StIdle);
   assign bus.done        = (state_q == StFin);
   assign bus.rd_en       = rd_fire;
   assign bus.rd_addr     = rd_idx_q;
   assign bus.lut_operand = pend_q ? bus.rd_z : '0;
   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;

endmodule

// File: tb/tb_softplus_grad_seq.sv
// Self-checking bench for softplus_grad_seq: buffer and LUT models, scoreboard queue fed at
// run start, negedge monitor comparing every accepted write against a reference model.
module tb_softplus_grad_seq;

   localparam int unsigned AW = 6;
   localparam int unsigned N  = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   softplus_grad_seq_if #(.ADDR_W(AW), .DATA_W(16)) bus ();

   softplus_grad_seq #(.ADDR_W(AW), .DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] z_mem [N];
   logic [15:0] d_mem [N];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rd_cnt, wr_cnt, done_cnt, first_rd, first_wr, last_wr, done_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Gradient LUT stand-in: spec-listed points, otherwise an arbitrary mix with bit 15 set often.
   function automatic logic [15:0] lut_fn(input logic [15:0] z);
      case (z)
         16'h0000: return 16'h0044;
         16'h0200: return 16'h0066;
         16'hFF80: return 16'h002A;
         16'h8000: return 16'h0000;
         default:  return {z[3:0] ^ z[15:12], z[11:0] ^ 12'h5A3};
      endcase
   endfunction

   // delta * grad in Q8.8, floored, clamped to the signed 16-bit range.
   function automatic logic [15:0] ref_grad(input logic [15:0] z, input logic [15:0] d);
      int g;
      int p;
      g = int'(lut_fn(z) & 16'h7FFF);
      p = int'($signed(d)) * g;
      p = (p >= 0) ? p / 256 : -((-p + 255) / 256);
      if (p > 32767)  p = 32767;
      if (p < -32768) p = -32768;
      return p[15:0];
   endfunction

   // Source layer buffers: registered read, output held while rd_en is low.
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_z     <= z_mem[bus.rd_addr];
         bus.rd_delta <= d_mem[bus.rd_addr];
      end
   end

   assign bus.lut_grad = lut_fn(bus.lut_operand);

   // Monitor: sampled on the falling edge, away from the active edge.
   logic          held_v = 1'b0;
   logic [AW-1:0] held_addr;
   logic [15:0]   held_data;
   logic          rd_prev = 1'b0;
   logic [AW-1:0] rd_prev_addr;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held_v  = 1'b0;
         rd_prev = 1'b0;
      end else begin
         if (rd_prev) check("lut_operand", 64'(bus.lut_operand), 64'(z_mem[rd_prev_addr]));
         rd_prev      = bus.rd_en;
         rd_prev_addr = bus.rd_addr;
         if (bus.rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (held_v) check("wr_stable", {bus.wr_en, bus.wr_addr, bus.wr_data},
                           {1'b1, held_addr, held_data});
         if (bus.wr_en && !bus.wr_ready) begin
            check("rd_en_in_stall", 64'(bus.rd_en), 64'd0);
            held_v    = 1'b1;
            held_addr = bus.wr_addr;
            held_data = bus.wr_data;
         end else begin
            held_v = 1'b0;
         end
         if (bus.wr_en && bus.wr_ready) begin
            wr_cnt++;
            last_wr = cyc;
            if (first_wr < 0) first_wr = cyc;
            if (sbq.size() == 0) begin
               check("sb_underflow", 64'(sbq.size()), 64'd1);
            end else begin
               e = sbq.pop_front();
               check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
               check("wr_data", 64'(bus.wr_data), 64'(e.data));
            end
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clr_stats();
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
      first_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
   endtask

   task automatic fill_and_expect(input int n);
      for (int i = 0; i < N; i++) begin
         z_mem[i] = 16'($urandom);
         d_mem[i] = 16'($urandom);
      end
      for (int i = 0; i < n; i++) sbq.push_back({AW'(i), ref_grad(z_mem[i], d_mem[i])});
   endtask

   // mode 0: always ready; 1: random ready; 2: stalled on cycles 5-9 then random;
   // 3: random ready plus a second start (len 5) while busy.
   task automatic run(input int n, input int mode, output int sc);
      int rel;
      clr_stats();
      bus.start    = 1'b1;
      bus.len      = 7'(n);
      bus.wr_ready = 1'b1;
      sc = cyc;
      for (int k = 0; k < 3000 && done_cyc < 0; k++) begin
         @(posedge clk); #1;
         rel = cyc - sc;
         bus.start = 1'b0;
         if (mode == 3 && rel == 3) begin
            bus.start = 1'b1;
            bus.len   = 7'd5;
         end
         case (mode)
            0:       bus.wr_ready = 1'b1;
            2:       bus.wr_ready = (rel < 5) ? 1'b1 : (rel <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
            default: bus.wr_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
      bus.wr_ready = 1'b1;
      check("done_seen", 64'(done_cyc >= 0), 64'd1);
      check("busy_after_done", 64'(bus.busy), 64'd0);
      check("done_once", 64'(done_cnt), 64'd1);
      check("rd_count", 64'(rd_cnt), 64'(n));
      check("wr_count", 64'(wr_cnt), 64'(n));
      check("sb_drained", 64'(sbq.size()), 64'd0);
      sbq.delete();
   endtask

   logic [47:0] outs;
   assign outs = {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.lut_operand,
                  bus.wr_en, bus.wr_addr, bus.wr_data};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      int n;
      int rd_snap;
      clr_stats();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.len = '0;
      bus.wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'(outs), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single element.
      fill_and_expect(0);
      z_mem[0] = 16'h0000;
      d_mem[0] = 16'h0100;
      sbq.push_back({AW'(0), 16'h0044});
      run(1, 0, sc);
      check("single_first_rd", 64'(first_rd - sc), 64'd1);
      check("single_latency", 64'(first_wr - first_rd), 64'd3);
      check("single_done_after_wr", 64'(done_cyc - last_wr), 64'd1);

      // Sign handling.
      fill_and_expect(0);
      z_mem[0] = 16'h0200; d_mem[0] = 16'hFF00;
      z_mem[1] = 16'hFF80; d_mem[1] = 16'h0200;
      z_mem[2] = 16'h8000;
      sbq.push_back({AW'(0), 16'hFF9A});
      sbq.push_back({AW'(1), 16'h0054});
      sbq.push_back({AW'(2), 16'h0000});
      run(3, 0, sc);

      // Full streaming, including index wrap.
      fill_and_expect(64);
      run(64, 0, sc);
      check("stream_latency", 64'(first_wr - first_rd), 64'd3);
      check("stream_back_to_back", 64'(last_wr - first_wr), 64'd63);
      check("stream_done_cycle", 64'(done_cyc - sc), 64'd68);
      check("wrapped_rd_addr", 64'(bus.rd_addr), 64'd0);

      // Backpressure.
      fill_and_expect(8);
      run(8, 2, sc);

      // Zero length.
      run(0, 0, sc);
      check("len0_done_cycle", 64'(done_cyc - sc), 64'd1);

      // Start while busy is ignored.
      fill_and_expect(12);
      run(12, 3, sc);

      // Random runs.
      for (int r = 0; r < 5; r++) begin
         n = (r == 0) ? 64 : int'($urandom_range(1, 64));
         fill_and_expect(n);
         run(n, 1, sc);
      end

      // Reset in the cycle of the 4th write.
      fill_and_expect(16);
      clr_stats();
      bus.start = 1'b1;
      bus.len   = 7'd16;
      for (int k = 0; k < 200 && wr_cnt < 3; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      check("pre_reset_writes", 64'(wr_cnt), 64'd3);
      check("fourth_write_present", 64'(bus.wr_en), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrun_reset_outputs", 64'(outs), 64'd0);
      rd_snap = rd_cnt;
      repeat (8) @(posedge clk);
      #1;
      check("no_done_after_reset", 64'(done_cnt), 64'd0);
      check("no_reads_after_reset", 64'(rd_cnt), 64'(rd_snap));
      check("no_writes_after_reset", 64'(wr_cnt), 64'd3);
      check("sb_left_after_reset", 64'(sbq.size()), 64'd13);
      sbq.delete();

      n = int'($urandom_range(1, 64));
      fill_and_expect(n);
      run(n, 1, sc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
